// File: rtl/map_pkg.sv
// Shared constants and the loader state type for the map sweep logic.
package map_pkg;

    localparam int NODES = 34;
    localparam int ROW_W = 9;
    localparam int COL_W = 32;
    localparam int WT_W  = 14;
    localparam int EC_W  = 16;

    localparam logic [WT_W-1:0] INF = WT_W'(10000);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EMIT,
        ST_ADVANCE,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/map_addr_counter.sv
// Row-major (row, column) walker over the NODES x NODES map with a last-entry flag.
module map_addr_counter
    import map_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NODES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NODES - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    // Step the column; on wrap move to the next row, holding the row on the final entry.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                if (r_row != ROW_LAST) begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/map_loader.sv
// Sweeps the edge-weight map and streams its entries into the adjacency RAM write port.
module map_loader
    import map_pkg::*;
#(
    parameter bit SKIP_INF = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] map_row,
    output logic [COL_W-1:0] map_col,
    input  logic [WT_W-1:0]  map_value,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [WT_W-1:0]  wr_weight,
    output logic [EC_W-1:0]  edge_count
);

    loader_state_t    r_state;
    loader_state_t    w_next_state;
    logic [ROW_W-1:0] r_wr_row;
    logic [COL_W-1:0] r_wr_col;
    logic [WT_W-1:0]  r_wr_weight;
    logic [EC_W-1:0]  r_edge_count;

    logic             w_start_accept;
    logic             w_advance;
    logic             w_last;
    logic             w_handshake;
    logic             w_counted;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;

    assign w_start_accept = (r_state == ST_IDLE) && start;
    assign w_advance      = (r_state == ST_ADVANCE);
    assign w_handshake    = (r_state == ST_EMIT) && wr_ready;
    assign w_counted      = (r_wr_weight != '0) && (r_wr_weight != INF);

    map_addr_counter u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_start_accept),
        .i_advance (w_advance),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    // State register; reset returns to IDLE and abandons any sweep in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection for the lookup / emit / advance walk.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next_state = ST_LOOKUP;
            ST_LOOKUP:  w_next_state = (SKIP_INF && (map_value == INF)) ? ST_ADVANCE : ST_EMIT;
            ST_EMIT:    if (wr_ready) w_next_state = ST_ADVANCE;
            ST_ADVANCE: w_next_state = w_last ? ST_DONE : ST_LOOKUP;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Capture the looked-up entry; it stays frozen through EMIT so stalls keep it stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_wr_weight <= '0;
        end else if (r_state == ST_LOOKUP) begin
            r_wr_row    <= w_row;
            r_wr_col    <= w_col;
            r_wr_weight <= map_value;
        end
    end

    // Count accepted finite off-diagonal weights, saturating, cleared by a new sweep.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_accept) begin
            r_edge_count <= '0;
        end else if (w_handshake && w_counted && (r_edge_count != '1)) begin
            r_edge_count <= r_edge_count + 1'b1;
        end
    end

    assign busy       = (r_state == ST_LOOKUP) || (r_state == ST_EMIT) || (r_state == ST_ADVANCE);
    assign done       = (r_state == ST_DONE);
    assign wr_valid   = (r_state == ST_EMIT);
    assign map_row    = w_row;
    assign map_col    = w_col;
    assign wr_row     = r_wr_row;
    assign wr_col     = r_wr_col;
    assign wr_weight  = r_wr_weight;
    assign edge_count = r_edge_count;

endmodule

// File: tb/tb_map_loader.sv
// Bench for map_loader: one skipping and one non-skipping instance fed from a generated map.
module tb_map_loader;
    import map_pkg::*;

    localparam int BUDGET = 20000;

    typedef struct {
        int r;
        int c;
        int w;
    } entry_t;

    typedef struct {
        int unit;
        int readyMode;
        int pulseA;
        int pulseB;
        int expEntries;
        int expSkipped;
        int expEdges;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic startU[2];
    logic wrReadyU[2];
    logic busyU[2];
    logic doneU[2];
    logic wrValidU[2];
    logic [ROW_W-1:0] mapRowU[2];
    logic [ROW_W-1:0] wrRowU[2];
    logic [COL_W-1:0] mapColU[2];
    logic [COL_W-1:0] wrColU[2];
    logic [WT_W-1:0]  mapValueU[2];
    logic [WT_W-1:0]  wrWeightU[2];
    logic [EC_W-1:0]  edgeCountU[2];

    int mapW[NODES][NODES];
    int ram[NODES][NODES];
    entry_t expQ[$];
    vec_t vecs[5];
    string names[5];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    map_loader #(.SKIP_INF(1'b1)) dutSkip (
        .clk(clk), .rst_n(rst_n), .start(startU[0]), .busy(busyU[0]), .done(doneU[0]),
        .map_row(mapRowU[0]), .map_col(mapColU[0]), .map_value(mapValueU[0]),
        .wr_valid(wrValidU[0]), .wr_ready(wrReadyU[0]), .wr_row(wrRowU[0]),
        .wr_col(wrColU[0]), .wr_weight(wrWeightU[0]), .edge_count(edgeCountU[0])
    );

    map_loader #(.SKIP_INF(1'b0)) dutAll (
        .clk(clk), .rst_n(rst_n), .start(startU[1]), .busy(busyU[1]), .done(doneU[1]),
        .map_row(mapRowU[1]), .map_col(mapColU[1]), .map_value(mapValueU[1]),
        .wr_valid(wrValidU[1]), .wr_ready(wrReadyU[1]), .wr_row(wrRowU[1]),
        .wr_col(wrColU[1]), .wr_weight(wrWeightU[1]), .edge_count(edgeCountU[1])
    );

    // Combinational map lookup standing in for the map ROM.
    function automatic logic [WT_W-1:0] lookup(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        if (int'(r) < NODES && int'(c) < NODES && int'(c) >= 0) begin
            return WT_W'(mapW[int'(r)][int'(c)]);
        end
        return '0;
    endfunction

    assign mapValueU[0] = lookup(mapRowU[0], mapColU[0]);
    assign mapValueU[1] = lookup(mapRowU[1], mapColU[1]);

    // Compare one observed value with the bench's own expectation.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Symmetric map: zero diagonal, 38 finite undirected edges, everything else INF.
    task automatic buildMap();
        int pairs;
        int a;
        int b;
        for (int r = 0; r < NODES; r++) begin
            for (int c = 0; c < NODES; c++) begin
                mapW[r][c] = (r == c) ? 0 : int'(INF);
            end
        end
        mapW[0][1] = 247;  mapW[1][0] = 247;
        mapW[1][2] = 258;  mapW[2][1] = 258;
        mapW[32][33] = 85; mapW[33][32] = 85;
        pairs = 3;
        while (pairs < 38) begin
            a = int'($urandom_range(1, NODES - 1));
            b = int'($urandom_range(1, NODES - 1));
            if (a != b && mapW[a][b] == int'(INF)) begin
                mapW[a][b] = int'($urandom_range(1, 9999));
                mapW[b][a] = mapW[a][b];
                pairs++;
            end
        end
    endtask

    // Reference sweep: row-major list of entries the loader should write.
    task automatic buildExpected(input bit skip, output int entries, output int skipped, output int edges);
        entry_t e;
        expQ.delete();
        entries = 0;
        skipped = 0;
        edges = 0;
        for (int r = 0; r < NODES; r++) begin
            for (int c = 0; c < NODES; c++) begin
                if (skip && mapW[r][c] == int'(INF)) begin
                    skipped++;
                end else begin
                    e.r = r;
                    e.c = c;
                    e.w = mapW[r][c];
                    expQ.push_back(e);
                    entries++;
                    if (mapW[r][c] != 0 && mapW[r][c] != int'(INF)) edges++;
                end
            end
        end
    endtask

    // Run one full sweep on the selected instance and score it against the model.
    task automatic applyStimulus(input int idx);
        vec_t v;
        int u;
        int cycle;
        int got;
        int firstValid;
        int doneCycle;
        int doneCount;
        int stall;
        int rangeBad;
        int ramBad;
        int dummyA;
        int dummyB;
        int dummyC;
        bit pulsedA;
        bit pulsedB;
        bit rdy;
        v = vecs[idx];
        u = v.unit;
        buildExpected(u == 0, dummyA, dummyB, dummyC);
        for (int r = 0; r < NODES; r++) for (int c = 0; c < NODES; c++) ram[r][c] = -1;
        cycle = 0; got = 0; firstValid = -1; doneCycle = -1; doneCount = 0;
        stall = 0; rangeBad = 0; ramBad = 0; pulsedA = 0; pulsedB = 0;
        @(negedge clk);
        startU[u] = 1'b1;
        wrReadyU[u] = 1'b1;
        while (cycle < BUDGET && !(doneCycle >= 0 && cycle >= doneCycle + 3)) begin
            @(negedge clk);
            cycle++;
            if (int'(mapRowU[u]) >= NODES || mapColU[u] >= COL_W'(NODES)) rangeBad++;
            startU[u] = 1'b0;
            if (v.pulseA >= 0 && !pulsedA && got == v.pulseA) begin startU[u] = 1'b1; pulsedA = 1; end
            if (v.pulseB >= 0 && !pulsedB && got == v.pulseB) begin startU[u] = 1'b1; pulsedB = 1; end
            rdy = 1'b1;
            if (v.readyMode == 1) begin
                rdy = 1'($urandom_range(0, 1));
            end else if (v.readyMode == 2 && stall < 5 &&
                         (stall > 0 || (wrValidU[u] && wrRowU[u] == 32 && wrColU[u] == 33))) begin
                rdy = 1'b0;
                stall++;
                checkOutput("stallValid", longint'(wrValidU[u]), 1);
                checkOutput("stallRow", longint'(wrRowU[u]), 32);
                checkOutput("stallCol", longint'(wrColU[u]), 33);
                checkOutput("stallWeight", longint'(wrWeightU[u]), longint'(mapW[32][33]));
            end
            wrReadyU[u] = rdy;
            if (wrValidU[u] && firstValid < 0) firstValid = cycle;
            if (wrValidU[u] && rdy) begin
                if (got < expQ.size()) begin
                    checkOutput("entryRow", longint'(wrRowU[u]), longint'(expQ[got].r));
                    checkOutput("entryCol", longint'(wrColU[u]), longint'(expQ[got].c));
                    checkOutput("entryWeight", longint'(wrWeightU[u]), longint'(expQ[got].w));
                end
                if (int'(wrRowU[u]) < NODES && wrColU[u] < COL_W'(NODES))
                    ram[int'(wrRowU[u])][int'(wrColU[u])] = int'(wrWeightU[u]);
                got++;
            end
            if (doneU[u]) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = cycle;
                    checkOutput("busyAtDone", longint'(busyU[u]), 0);
                end
            end
        end
        wrReadyU[u] = 1'b1;
        startU[u] = 1'b0;
        checkOutput({names[idx], "_doneSeen"}, longint'(doneCycle >= 0), 1);
        checkOutput({names[idx], "_entries"}, got, v.expEntries);
        checkOutput({names[idx], "_donePulses"}, doneCount, 1);
        checkOutput({names[idx], "_edgeCount"}, longint'(edgeCountU[u]), v.expEdges);
        checkOutput({names[idx], "_busyAfter"}, longint'(busyU[u]), 0);
        checkOutput({names[idx], "_firstValid"}, firstValid, 2);
        checkOutput({names[idx], "_addrRange"}, rangeBad, 0);
        if (v.readyMode == 0) begin
            checkOutput({names[idx], "_sweepCycles"}, doneCycle, 1 + 3 * v.expEntries + 2 * v.expSkipped);
        end
        if (v.readyMode == 1) begin
            for (int r = 0; r < NODES; r++)
                for (int c = 0; c < NODES; c++)
                    if (ram[r][c] != mapW[r][c]) ramBad++;
            checkOutput({names[idx], "_ramContents"}, ramBad, 0);
        end
    endtask

    // Reset partway through a sweep must abort it with nothing further emitted.
    task automatic abortTest();
        int got;
        int cycle;
        int strayValid;
        int dummyA;
        int dummyB;
        int dummyC;
        buildExpected(1'b1, dummyA, dummyB, dummyC);
        got = 0;
        cycle = 0;
        strayValid = 0;
        @(negedge clk);
        startU[0] = 1'b1;
        wrReadyU[0] = 1'b1;
        while (got < 20 && cycle < BUDGET) begin
            @(negedge clk);
            cycle++;
            startU[0] = 1'b0;
            if (wrValidU[0]) begin
                checkOutput("abortEntryRow", longint'(wrRowU[0]), longint'(expQ[got].r));
                checkOutput("abortEntryCol", longint'(wrColU[0]), longint'(expQ[got].c));
                got++;
            end
        end
        checkOutput("abortReached20", got, 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abortValid", longint'(wrValidU[0]), 0);
        checkOutput("abortBusy", longint'(busyU[0]), 0);
        checkOutput("abortEdgeCount", longint'(edgeCountU[0]), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wrValidU[0] || busyU[0]) strayValid++;
        end
        checkOutput("abortQuiet", strayValid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            startU[i] = 1'b0;
            wrReadyU[i] = 1'b1;
        end
        buildMap();

        names[0] = "skipReadyHigh";
        names[1] = "allEntries";
        names[2] = "backpressure";
        names[3] = "randomReady";
        names[4] = "startWhileBusy";
        vecs[0] = '{unit: 0, readyMode: 0, pulseA: -1, pulseB: -1, expEntries: 0, expSkipped: 0, expEdges: 0};
        vecs[1] = '{unit: 1, readyMode: 0, pulseA: -1, pulseB: -1, expEntries: 0, expSkipped: 0, expEdges: 0};
        vecs[2] = '{unit: 0, readyMode: 2, pulseA: -1, pulseB: -1, expEntries: 0, expSkipped: 0, expEdges: 0};
        vecs[3] = '{unit: 1, readyMode: 1, pulseA: -1, pulseB: -1, expEntries: 0, expSkipped: 0, expEdges: 0};
        vecs[4] = '{unit: 0, readyMode: 0, pulseA: 3, pulseB: 50, expEntries: 0, expSkipped: 0, expEdges: 0};
        for (int i = 0; i < 5; i++) begin
            buildExpected(vecs[i].unit == 0, vecs[i].expEntries, vecs[i].expSkipped, vecs[i].expEdges);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput("resetBusy", longint'(busyU[u]), 0);
            checkOutput("resetDone", longint'(doneU[u]), 0);
            checkOutput("resetValid", longint'(wrValidU[u]), 0);
            checkOutput("resetWrRow", longint'(wrRowU[u]), 0);
            checkOutput("resetWrCol", longint'(wrColU[u]), 0);
            checkOutput("resetWrWeight", longint'(wrWeightU[u]), 0);
            checkOutput("resetMapRow", longint'(mapRowU[u]), 0);
            checkOutput("resetMapCol", longint'(mapColU[u]), 0);
            checkOutput("resetEdgeCount", longint'(edgeCountU[u]), 0);
        end
        rst_n = 1'b1;

        checkOutput("modelSkipEntries", vecs[0].expEntries, 110);
        checkOutput("modelEdges", vecs[0].expEdges, 76);

        for (int i = 0; i < 4; i++) applyStimulus(i);
        abortTest();
        applyStimulus(0);
        applyStimulus(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
